// File: rtl/stream_rate_bridge_if.sv
// Purpose: bundles the sample-path signals of stream_rate_bridge so the
// bridge and its environment connect through a single port.
//   slave  : the bridge's view (ADC/DSP-result/DAC-strobe/clear in; DSP
//            feed, DAC code, levels and flags out)
//   master : the environment's view (ADC, DSP core model, DAC tick source)
// Signals:
//   din/din_valid     ADC sample and qualifier
//   dsp_en/dsp_din    DSP core clock-enable and its input sample
//   dsp_dout          DSP core result
//   dac_strobe        DAC update tick
//   dac_data          offset-binary DAC code
//   in_level          in-FIFO occupancy
//   out_level         out-FIFO occupancy
//   ovf/udf           sticky overflow / underrun flags
//   clr_flags         clear for ovf/udf
interface stream_rate_bridge_if #(
  parameter int DATA_WIDTH = 12,
  parameter int DAC_WIDTH  = 8,
  parameter int FIFO_AW    = 4
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  dsp_en;
  logic [DATA_WIDTH-1:0] dsp_din;
  logic [DATA_WIDTH-1:0] dsp_dout;
  logic                  dac_strobe;
  logic [DAC_WIDTH-1:0]  dac_data;
  logic [FIFO_AW:0]      in_level;
  logic [FIFO_AW:0]      out_level;
  logic                  ovf;
  logic                  udf;
  logic                  clr_flags;

  modport slave (
    input  din, din_valid, dsp_dout, dac_strobe, clr_flags,
    output dsp_en, dsp_din, dac_data, in_level, out_level, ovf, udf
  );

  modport master (
    output din, din_valid, dsp_dout, dac_strobe, clr_flags,
    input  dsp_en, dsp_din, dac_data, in_level, out_level, ovf, udf
  );
endinterface

// File: rtl/stream_rate_bridge.sv
// Purpose: single-clock sample pipeline ADC -> decimator -> in-FIFO ->
// fixed-latency DSP core (credit gated) -> out-FIFO -> zero-order-hold
// interpolator -> offset-binary DAC code, with sticky overflow/underrun flags.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset; discards all buffered/in-flight data
//   bus  stream_rate_bridge_if.slave (see interface file for signal list)
// The interface instance must be built with the same DATA_WIDTH, DAC_WIDTH
// and FIFO_AW as this module.
module stream_rate_bridge #(
  parameter int DATA_WIDTH  = 12,
  parameter int DAC_WIDTH   = 8,
  parameter int DECIM_LOG2  = 0,
  parameter int DECIM_MODE  = 0,
  parameter int INTERP      = 1,
  parameter int FIFO_AW     = 4,
  parameter int DSP_LATENCY = 2
) (
  input logic                 clk,
  input logic                 rst,
  stream_rate_bridge_if.slave bus
);
  localparam int D  = 1 << FIFO_AW;
  localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int SW = DATA_WIDTH + DECIM_LOG2;
  localparam int HW = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam int FW = $clog2(DSP_LATENCY + 1);
  localparam logic [DAC_WIDTH-1:0] MID = {1'b1, {(DAC_WIDTH-1){1'b0}}};

  // ---------------- decimator ----------------
  logic signed [DATA_WIDTH-1:0] din_s;
  logic [CW-1:0]                grp_cnt;
  logic signed [SW-1:0]         acc;
  logic signed [SW-1:0]         acc_sum;
  logic                         grp_first;
  logic                         grp_last;
  logic                         fwd_valid;
  logic [DATA_WIDTH-1:0]        fwd_data;
  logic                         dec_valid;
  logic [DATA_WIDTH-1:0]        dec_data;

  assign din_s = bus.din;

  always_comb begin
    grp_first = (DECIM_LOG2 == 0) || (grp_cnt == '0);
    grp_last  = (DECIM_LOG2 == 0) || (grp_cnt == '1);
    acc_sum   = acc + SW'(din_s);
    if (DECIM_MODE == 1) begin
      fwd_valid = bus.din_valid && grp_last;
      // arithmetic shift truncates toward minus infinity
      fwd_data  = DATA_WIDTH'(acc_sum >>> DECIM_LOG2);
    end else begin
      fwd_valid = bus.din_valid && grp_first;
      fwd_data  = bus.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_cnt   <= '0;
      acc       <= '0;
      dec_valid <= 1'b0;
      dec_data  <= '0;
    end else begin
      dec_valid <= fwd_valid;
      if (fwd_valid) dec_data <= fwd_data;
      if (bus.din_valid) begin
        grp_cnt <= (DECIM_LOG2 == 0) ? '0 : grp_cnt + 1'b1;
        acc     <= grp_last ? '0 : acc_sum;
      end
    end
  end

  // ---------------- in-FIFO ----------------
  logic [DATA_WIDTH-1:0] in_mem [D];
  logic [FIFO_AW:0]      in_wr;
  logic [FIFO_AW:0]      in_rd;
  logic                  in_empty;
  logic                  in_full;
  logic                  in_push;
  logic                  ovf_set;

  assign in_empty = (in_wr == in_rd);
  assign in_full  = (in_wr[FIFO_AW] != in_rd[FIFO_AW]) &&
                    (in_wr[FIFO_AW-1:0] == in_rd[FIFO_AW-1:0]);
  // a full FIFO drops the write even when the DSP pops in the same cycle
  assign in_push  = dec_valid && !in_full;
  assign ovf_set  = dec_valid && in_full;

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr[FIFO_AW-1:0]] <= dec_data;
  end

  // ---------------- DSP credit gating ----------------
  logic [DSP_LATENCY-1:0] vsr;
  logic [FW-1:0]          inflight;
  logic                   wb;
  logic                   dsp_en;
  logic [FIFO_AW:0]       out_level;

  assign wb = vsr[DSP_LATENCY-1];
  // out-FIFO occupancy plus results still in the DSP never exceeds depth,
  // so every write-back is guaranteed a slot
  assign dsp_en = !in_empty && ((int'(out_level) + int'(inflight)) < D);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_wr    <= '0;
      in_rd    <= '0;
      vsr      <= '0;
      inflight <= '0;
    end else begin
      if (in_push) in_wr <= in_wr + 1'b1;
      if (dsp_en)  in_rd <= in_rd + 1'b1;
      vsr      <= (vsr << 1) | DSP_LATENCY'(dsp_en);
      inflight <= inflight + FW'(dsp_en) - FW'(wb);
    end
  end

  // ---------------- out-FIFO + interpolator ----------------
  logic [DATA_WIDTH-1:0] out_mem [D];
  logic [FIFO_AW:0]      out_wr;
  logic [FIFO_AW:0]      out_rd;
  logic                  out_empty;
  logic                  out_pop;
  logic                  udf_set;
  logic [DATA_WIDTH-1:0] out_head;
  logic [HW-1:0]         hold;
  logic [DAC_WIDTH-1:0]  dac_reg;
  logic                  ovf;
  logic                  udf;

  assign out_empty = (out_wr == out_rd);
  assign out_level = out_wr - out_rd;
  assign out_head  = out_mem[out_rd[FIFO_AW-1:0]];
  assign out_pop   = bus.dac_strobe && (hold == '0) && !out_empty;
  assign udf_set   = bus.dac_strobe && (hold == '0) && out_empty;

  always_ff @(posedge clk) begin
    if (wb) out_mem[out_wr[FIFO_AW-1:0]] <= bus.dsp_dout;
  end

  // an underrun keeps hold at 0 so the next strobe retries the pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_wr  <= '0;
      out_rd  <= '0;
      hold    <= '0;
      dac_reg <= MID;
    end else begin
      if (wb)      out_wr <= out_wr + 1'b1;
      if (out_pop) out_rd <= out_rd + 1'b1;
      if (bus.dac_strobe) begin
        if (hold == '0) begin
          if (!out_empty) begin
            // flipping the sign bit is the same as adding mid-scale
            dac_reg <= out_head[DATA_WIDTH-1 -: DAC_WIDTH] ^ MID;
            hold    <= (INTERP > 1) ? HW'(1) : '0;
          end
        end else begin
          hold <= (hold == HW'(INTERP - 1)) ? '0 : hold + 1'b1;
        end
      end
    end
  end

  // a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf_set || (ovf && !bus.clr_flags);
      udf <= udf_set || (udf && !bus.clr_flags);
    end
  end

  assign bus.dsp_en    = dsp_en;
  assign bus.dsp_din   = in_mem[in_rd[FIFO_AW-1:0]];
  assign bus.dac_data  = dac_reg;
  assign bus.in_level  = in_wr - in_rd;
  assign bus.out_level = out_level;
  assign bus.ovf       = ovf;
  assign bus.udf       = udf;
endmodule
